// File: rtl/logic_engine_pkg.sv
// Shared definitions for the logic_engine arbiter slice: opcode values and
// the arbiter FSM state encoding.
package logic_engine_pkg;

    localparam logic [1:0] OP_OR   = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_NOR  = 2'b10;
    localparam logic [1:0] OP_AND  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_arb_rr.sv
// logic_arb_rr: combinational arbiter turning a request vector into a
// one-hot grant plus the winner index.
// Default build: round-robin search starting at ptr, wrapping NUM_REQ-1 -> 0.
// With LOGIC_ARB_FIXED_PRI_EN defined: fixed priority, lowest index wins,
// and ptr is ignored.
module logic_arb_rr #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);

`ifndef LOGIC_ARB_FIXED_PRI_EN
    localparam logic [ID_W:0] N_W = (ID_W+1)'(NUM_REQ);
    logic [ID_W:0] sum;
`endif
    logic [ID_W-1:0] idx;

    // Scan candidates in priority order and grant the first active one.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
`ifndef LOGIC_ARB_FIXED_PRI_EN
        sum       = '0;
`endif
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef LOGIC_ARB_FIXED_PRI_EN
            idx = ID_W'(i);
`else
            // ptr + i can exceed NUM_REQ-1 by less than NUM_REQ, so one subtract wraps it
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            idx = sum[ID_W-1:0];
`endif
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/logic_engine.sv
// logic_engine: 8-bit bitwise OR/NAND/NOR/AND unit, purely combinational.
module logic_engine
    import logic_engine_pkg::*;
(
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [1:0] opcode,
    output logic [7:0] result
);

    // Select the bitwise function named by the opcode.
    always_comb begin
        case (opcode)
            OP_OR:   result = A | B;
            OP_NAND: result = ~(A & B);
            OP_NOR:  result = ~(A | B);
            default: result = A & B;
        endcase
    end

endmodule

// File: rtl/logic_engine_arbiter.sv
// logic_engine_arbiter: shares a single logic_engine between NUM_REQ
// requesters. Arbitrates, latches the winner's operands, runs the engine for
// one cycle and returns the registered result with the winner's ID over a
// valid/ready response port. FSM: IDLE -> EXEC -> RESP -> IDLE.
// Build option LOGIC_ARB_FIXED_PRI_EN: fixed priority (lowest index wins),
// no round-robin pointer. Default build is round-robin.
module logic_engine_arbiter
    import logic_engine_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]      req_op,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic [ID_W-1:0]           resp_id,
    output logic                      busy
);

    state_t state;
    state_t state_next;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic [ID_W-1:0]    ptr;
    logic               accept;

    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic [1:0]         sel_op;

    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [1:0]         op_q;
    logic [ID_W-1:0]    id_q;
    logic [DATA_W-1:0]  eng_result;

    logic_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    logic_engine u_engine (
        .A      (a_q),
        .B      (b_q),
        .opcode (op_q),
        .result (eng_result)
    );

    assign accept = (state == IDLE) && grant_any;

`ifdef LOGIC_ARB_FIXED_PRI_EN
    assign ptr = '0;
`else
    // Round-robin pointer: after each grant, the winner's successor gets top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            if (grant_id == ID_W'(NUM_REQ-1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_id + ID_W'(1);
            end
        end
    end
`endif

    // Pick the winner's operand and opcode slices from the packed buses.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a  = req_a[i*DATA_W +: DATA_W];
                sel_b  = req_b[i*DATA_W +: DATA_W];
                sel_op = req_op[i*2 +: 2];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (resp_valid && resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: grant only while idle and out of reset; busy while an op is in flight.
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if (state == IDLE && !rst) begin
            req_ready = grant;
        end
        if (state == EXEC || state == RESP) begin
            busy = 1'b1;
        end
    end

    // Latch the winning request's operands on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            id_q <= '0;
        end else if (accept) begin
            a_q  <= sel_a;
            b_q  <= sel_b;
            op_q <= sel_op;
            id_q <= grant_id;
        end
    end

    // Capture the engine result after EXEC and hold it until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
        end else if (state == EXEC) begin
            resp_valid <= 1'b1;
            resp_data  <= eng_result;
            resp_id    <= id_q;
        end else if (state == RESP && resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_engine_arbiter.sv
// Directed testbench for logic_engine_arbiter (NUM_REQ=4, DATA_W=8).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_logic_engine_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_op;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_data;
    logic [1:0]  resp_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic_engine_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        req_a[idx*8 +: 8] = a;
        req_b[idx*8 +: 8] = b;
        req_op[idx*2 +: 2] = op;
        req_valid[idx] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b0001;
        resp_ready = 1'b0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        tick();
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", resp_valid); end
        checks++; if (resp_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", resp_data); end
        checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", resp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        req_valid = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        resp_ready = 1'b1;
        set_req(0, 8'hAA, 8'h55, 2'b00);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_exec_busy got %b want 1", busy); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_exec_valid got %b want 0", resp_valid); end
        tick();
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid got %b want 1", resp_valid); end
        checks++; if (resp_data !== 8'hFF) begin errors++; $display("FAIL single_data got %h want ff", resp_data); end
        checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d want 0", resp_id); end
        tick();
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got valid=%b busy=%b want 0 0", resp_valid, busy); end
    endtask

    task automatic test_two_req();
        do_reset();
        resp_ready = 1'b1;
        set_req(1, 8'hF0, 8'h0F, 2'b10);
        set_req(2, 8'hF0, 8'hCC, 2'b11);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL two_first_grant got %b want 0010", req_ready); end
        tick();
        req_valid[1] = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL two_exec_ready got %b want 0000", req_ready); end
        tick();
        checks++; if (resp_data !== 8'h00 || resp_id !== 2'd1) begin errors++; $display("FAIL two_first_resp got %h/%0d want 00/1", resp_data, resp_id); end
        tick();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL two_second_grant got %b want 0100", req_ready); end
        tick();
        req_valid[2] = 1'b0;
        tick();
        checks++; if (resp_data !== 8'hC0 || resp_id !== 2'd2) begin errors++; $display("FAIL two_second_resp got %h/%0d want c0/2", resp_data, resp_id); end
        tick();
    endtask

    task automatic test_rr_order();
        logic [3:0] exp_ready;
        logic [1:0] exp_id;
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 8'h10 + 8'(i), 8'h00, 2'b00);
        end
        #1;
        for (int g = 0; g < 8; g++) begin
`ifdef LOGIC_ARB_FIXED_PRI_EN
            exp_id = 2'd0;
`else
            exp_id = 2'(g % 4);
`endif
            exp_ready = 4'b0001 << exp_id;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_grant%0d got %b want %b", g, req_ready, exp_ready); end
            tick();
            tick();
            checks++; if (resp_id !== exp_id || resp_data !== (8'h10 + 8'(exp_id))) begin errors++; $display("FAIL rr_resp%0d got %0d/%h want %0d/%h", g, resp_id, resp_data, exp_id, 8'h10 + 8'(exp_id)); end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_resp_stall();
        resp_ready = 1'b0;
        set_req(3, 8'hA5, 8'hAA, 2'b01);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL stall_grant got %b want 1000", req_ready); end
        tick();
        req_valid[3] = 1'b0;
        tick();
        set_req(0, 8'h0F, 8'hF0, 2'b00);
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 8'h5F || resp_id !== 2'd3 || req_ready !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b d=%h id=%0d rdy=%b busy=%b want 1 5f 3 0000 1",
                         k, resp_valid, resp_data, resp_id, req_ready, busy);
            end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_release got v=%b busy=%b want 0 0", resp_valid, busy); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_next_idle_grant got %b want 0001", req_ready); end
        req_valid[0] = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL withdraw_ready got %b want 0000", req_ready); end
        tick();
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL withdraw_idle got busy=%b v=%b want 0 0", busy, resp_valid); end
    endtask

    task automatic test_back_to_back();
        resp_ready = 1'b1;
        set_req(1, 8'h81, 8'h18, 2'b01);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_grant0 got %b want 0010", req_ready); end
        tick();
        set_req(1, 8'h81, 8'h18, 2'b10);
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL b2b_exec_ready got %b want 0000", req_ready); end
        tick();
        checks++; if (resp_data !== 8'hFF || resp_id !== 2'd1) begin errors++; $display("FAIL b2b_resp0 got %h/%0d want ff/1", resp_data, resp_id); end
        tick();
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_grant1 got %b want 0010", req_ready); end
        tick();
        req_valid[1] = 1'b0;
        tick();
        checks++; if (resp_data !== 8'h66 || resp_id !== 2'd1) begin errors++; $display("FAIL b2b_resp1 got %h/%0d want 66/1", resp_data, resp_id); end
        tick();
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        resp_ready = 1'b1;
        set_req(0, 8'h3C, 8'h00, 2'b00);
        #1;
        tick();
        req_valid = '0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy got %b want 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_async got busy=%b v=%b want 0 0", busy, resp_valid); end
        tick();
        checks++; if (resp_valid !== 1'b0 || resp_data !== 8'h00) begin errors++; $display("FAIL midrst_hold got v=%b d=%h want 0 00", resp_valid, resp_data); end
        rst = 1'b0;
        set_req(0, 8'h3C, 8'h00, 2'b00);
        set_req(1, 8'h11, 8'h22, 2'b00);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_tie got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++; if (resp_data !== 8'h3C || resp_id !== 2'd0) begin errors++; $display("FAIL midrst_resp got %h/%0d want 3c/0", resp_data, resp_id); end
        tick();
    endtask

    task automatic test_corners();
        resp_ready = 1'b1;
        set_req(2, 8'h00, 8'h00, 2'b00);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL corner_or_grant got %b want 0100", req_ready); end
        tick();
        req_valid[2] = 1'b0;
        tick();
        checks++; if (resp_data !== 8'h00 || resp_id !== 2'd2) begin errors++; $display("FAIL corner_or_zero got %h/%0d want 00/2", resp_data, resp_id); end
        tick();
        set_req(2, 8'hFF, 8'hFF, 2'b11);
        #1;
        tick();
        req_valid[2] = 1'b0;
        tick();
        checks++; if (resp_data !== 8'hFF || resp_id !== 2'd2) begin errors++; $display("FAIL corner_and_ones got %h/%0d want ff/2", resp_data, resp_id); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_two_req();
        test_rr_order();
        test_resp_stall();
        test_back_to_back();
        test_reset_mid_exec();
        test_corners();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
